// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: in-order writeback (A) vs. FIFO-buffered long-latency unit (B).
// Optional same-cycle B bypass on an idle port is enabled by defining RF_WB_ARB_BYPASS_EN.
module rf_wb_arb #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_W-1:0]     a_rd,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_W-1:0]     b_rd,
  input  logic [DATA_W-1:0]     b_data,
  output logic [ADDR_W-1:0]     rf_rd,
  output logic                  rf_write_e,
  output logic [DATA_W-1:0]     rf_write_d,
  output logic [(1<<ADDR_W)-1:0] b_pending_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ST_W-1:0]   starve_q, starve_d;

  logic              out_we_q, out_b_q;
  logic [ADDR_W-1:0] out_rd_q;
  logic [DATA_W-1:0] out_data_q;

  logic              b_present, full, force_b, bypass;
  logic              grant_a, pop, push, grant;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   mask_d;
  logic [PTR_W-1:0]  mask_idx;

  assign b_present = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign b_ready   = !rst && !full;
  assign force_b   = (starve_q == ST_W'(STARVE_LIMIT)) && b_present;
  assign a_ready   = !rst && !force_b;

`ifdef RF_WB_ARB_BYPASS_EN
  // Idle port and empty FIFO: send B straight to the output stage, skipping the FIFO.
  assign bypass = !rst && !b_present && !a_valid && b_valid;
`else
  assign bypass = 1'b0;
`endif

  assign grant_a = !rst && a_valid && !force_b;
  assign pop     = !rst && b_present && !grant_a;
  assign push    = b_valid && b_ready && !bypass;
  assign grant   = grant_a || pop || bypass;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    sel_rd   = fifo_rd_q[rptr_q];
    sel_data = fifo_data_q[rptr_q];
    if (grant_a) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end else if (bypass) begin
      sel_rd   = b_rd;
      sel_data = b_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!b_present || pop) begin
      starve_d = '0;
    end else if (starve_q != ST_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      out_we_q   <= 1'b0;
      out_b_q    <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      if (grant) begin
        out_rd_q   <= sel_rd;
        out_data_q <= sel_data;
        // x0 writes complete their handshake but never reach the register file.
        out_we_q   <= (sel_rd != '0);
        out_b_q    <= !grant_a;
      end else begin
        out_we_q <= 1'b0;
        out_b_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= b_rd;
      fifo_data_q[wptr_q] <= b_data;
    end
  end

  always_comb begin
    mask_d   = '0;
    mask_idx = rptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mask_idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) mask_d[fifo_rd_q[mask_idx]] = 1'b1;
    end
    if (out_we_q && out_b_q) mask_d[out_rd_q] = 1'b1;
    mask_d[0] = 1'b0;
  end

  assign b_pending_mask = mask_d;
  assign rf_rd          = out_rd_q;
  assign rf_write_e     = out_we_q;
  assign rf_write_d     = out_data_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb: vector table plus starvation, reset-flush and bypass sequences.
module tb_rf_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rf_rd;
  logic [31:0] a_data, b_data, rf_write_d;
  logic        rf_write_e;
  logic [31:0] b_pending_mask;

  int n_chk  = 0;
  int n_fail = 0;

  rf_wb_arb dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_rd           (a_rd),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_rd           (b_rd),
    .b_data         (b_data),
    .rf_rd          (rf_rd),
    .rf_write_e     (rf_write_e),
    .rf_write_d     (rf_write_d),
    .b_pending_mask (b_pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        xar;
    logic        xbr;
    logic        xwe;
    logic        cko;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic [31:0] xmask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int r, input int av, input int ard, input int ad,
                              input int bv, input int brd, input int bd,
                              input int xar, input int xbr, input int xwe, input int cko,
                              input int xrd, input int xd, input int xmask);
    vec_t v;
    v.rst = 1'(r);    v.av = 1'(av);   v.ard = 5'(ard);  v.ad = 32'(ad);
    v.bv = 1'(bv);    v.brd = 5'(brd); v.bd = 32'(bd);
    v.xar = 1'(xar);  v.xbr = 1'(xbr); v.xwe = 1'(xwe);  v.cko = 1'(cko);
    v.xrd = 5'(xrd);  v.xd = 32'(xd);  v.xmask = 32'(xmask);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input int av, input int ard, input int ad,
                       input int bv, input int brd, input int bd);
    rst = 1'(r); a_valid = 1'(av); a_rd = 5'(ard); a_data = 32'(ad);
    b_valid = 1'(bv); b_rd = 5'(brd); b_data = 32'(bd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int we, input int rd, input int d,
                         input int mask);
    chk({tag, "_we"}, 32'(rf_write_e), 32'(we));
    if (we != 0) begin
      chk({tag, "_rd"}, 32'(rf_rd), 32'(rd));
      chk({tag, "_data"}, rf_write_d, 32'(d));
    end
    chk({tag, "_mask"}, b_pending_mask, 32'(mask));
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(int'(v.rst), int'(v.av), int'(v.ard), int'(v.ad), int'(v.bv), int'(v.brd),
          int'(v.bd));
    #1;
    chk({tag, "_a_ready"}, 32'(a_ready), 32'(v.xar));
    chk({tag, "_b_ready"}, 32'(b_ready), 32'(v.xbr));
    tick();
    chk({tag, "_we"}, 32'(rf_write_e), 32'(v.xwe));
    if (v.cko) begin
      chk({tag, "_rd"}, 32'(rf_rd), 32'(v.xrd));
      chk({tag, "_data"}, rf_write_d, v.xd);
    end
    chk({tag, "_mask"}, b_pending_mask, v.xmask);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    //          rst av ard ad  bv brd bd   ar br  we cko rd  d   mask
    tbl.push_back(mk(1, 0, 0,  0,  0, 0, 0,   0, 0,  0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 4,  42, 0, 0, 0,   1, 1,  1, 1, 4,  42, 0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  0, 1, 4,  42, 0));
    tbl.push_back(mk(0, 1, 3,  5,  1, 1, 11,  1, 1,  1, 1, 3,  5,  'h02));
    tbl.push_back(mk(0, 1, 6,  6,  1, 2, 22,  1, 1,  1, 1, 6,  6,  'h06));
    tbl.push_back(mk(0, 1, 7,  7,  1, 3, 33,  1, 1,  1, 1, 7,  7,  'h0E));
    tbl.push_back(mk(0, 1, 8,  8,  1, 4, 44,  1, 1,  1, 1, 8,  8,  'h1E));
    tbl.push_back(mk(0, 1, 9,  9,  0, 0, 0,   1, 0,  1, 1, 9,  9,  'h1E));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 0,  1, 1, 1,  11, 'h1E));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  1, 1, 2,  22, 'h1C));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  1, 1, 3,  33, 'h18));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  1, 1, 4,  44, 'h10));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  0, 1, 4,  44, 0));
    tbl.push_back(mk(0, 1, 0,  7,  0, 0, 0,   1, 1,  0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 10, 1,  1, 0, 5,   1, 1,  1, 1, 10, 1,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0,   1, 1,  0, 0, 0,  0,  0));

    tick();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Starvation: B x2=99 loses STARVE_LIMIT cycles to A, then is forced through.
    drive(0, 1, 1, 100, 1, 2, 99);
    #1 chk("starve_push_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk_out("starve_push", 1, 1, 100, 'h04);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 1, 100 + k, 0, 0, 0);
      #1 chk($sformatf("starve_lose%0d_a_ready", k), 32'(a_ready), 32'd1);
      tick();
      chk_out($sformatf("starve_lose%0d", k), 1, 1, 100 + k, 'h04);
    end
    drive(0, 1, 1, 200, 0, 0, 0);
    #1 chk("starve_force_a_ready", 32'(a_ready), 32'd0);
    tick();
    chk_out("starve_force", 1, 2, 99, 'h04);
    drive(0, 1, 1, 201, 0, 0, 0);
    #1 chk("starve_after_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk_out("starve_after", 1, 1, 201, 0);

    // Reset with three queued B writes: all are discarded.
    drive(0, 1, 1, 1, 1, 3, 30);
    tick();
    drive(0, 1, 1, 2, 1, 4, 40);
    tick();
    drive(0, 1, 1, 3, 1, 5, 50);
    tick();
    chk_out("rstq_fill", 1, 1, 3, 'h38);
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstq_in_rst_a_ready", 32'(a_ready), 32'd0);
    chk("rstq_in_rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk_out("rstq_after_rst", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rstq_idle%0d_b_ready", k), 32'(b_ready), 32'd1);
      tick();
      chk_out($sformatf("rstq_idle%0d", k), 0, 0, 0, 0);
    end

    // Lone B write x5=123 into an empty FIFO.
    drive(0, 0, 0, 0, 1, 5, 123);
    #1 chk("byp_b_ready", 32'(b_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef RF_WB_ARB_BYPASS_EN
    chk_out("byp_n1", 1, 5, 123, 'h20);
    tick();
    chk_out("byp_n2", 0, 0, 0, 0);
`else
    chk_out("byp_n1", 0, 0, 0, 'h20);
    tick();
    chk_out("byp_n2", 1, 5, 123, 'h20);
    tick();
    chk_out("byp_n3", 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
